// File: rtl/pingpong_chunk_buffer.sv
// pingpong_chunk_buffer
//   Multi-channel ping-pong chunk buffer between the I2S frame interface and
//   the block processor. Incoming frames fill rx[bank_sel] while the
//   processor reads rx[~bank_sel] and writes tx[~bank_sel]. The previously
//   processed tx[bank_sel] is played back one frame per incoming frame.
//   Banks swap when the last frame of a chunk arrives.
//
//   Optional build macro: PINGPONG_MUTE_ON_OVERRUN_EN
//     When defined, a swap that raises overrun mutes playback for the whole
//     following play chunk, because that tx bank was never finished.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   frame_valid       one-cycle strobe, frame_in holds a complete frame
//   frame_in          NUM_CHANNELS samples, channel 0 in the LSBs
//   frame_out         playback frame (same packing), updated one cycle later
//   frame_out_valid   one-cycle pulse when frame_out updates
//   chunk_pulse       one-cycle pulse, a new chunk is ready for the processor
//   bank_sel          current fill/play bank
//   proc_rd_*         processor read port, 1-cycle latency, rx[~bank_sel]
//   proc_wr_*         processor write port, tx[~bank_sel]
//   proc_done         processor finished its chunk
//   proc_busy         processor chunk outstanding
//   overrun           sticky: a swap arrived while the processor was busy
//   overrun_clr       clears overrun (a simultaneous new overrun wins)
module pingpong_chunk_buffer #(
  parameter int unsigned SAMPLE_SIZE    = 24,
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned CH_BITS        = 1,
  parameter int unsigned CHUNK_LEN      = 64,
  parameter int unsigned CHUNK_PTR_BITS = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                frame_valid,
  input  logic [NUM_CHANNELS*SAMPLE_SIZE-1:0] frame_in,
  output logic [NUM_CHANNELS*SAMPLE_SIZE-1:0] frame_out,
  output logic                                frame_out_valid,
  output logic                                chunk_pulse,
  output logic                                bank_sel,
  input  logic                                proc_rd_en,
  input  logic [CH_BITS-1:0]                  proc_rd_ch,
  input  logic [CHUNK_PTR_BITS-1:0]           proc_rd_ptr,
  output logic [SAMPLE_SIZE-1:0]              proc_rd_data,
  output logic                                proc_rd_valid,
  input  logic                                proc_wr_en,
  input  logic [CH_BITS-1:0]                  proc_wr_ch,
  input  logic [CHUNK_PTR_BITS-1:0]           proc_wr_ptr,
  input  logic [SAMPLE_SIZE-1:0]              proc_wr_data,
  input  logic                                proc_done,
  output logic                                proc_busy,
  output logic                                overrun,
  input  logic                                overrun_clr
);

  localparam int unsigned FRAME_W = NUM_CHANNELS * SAMPLE_SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                    state;
  logic [CHUNK_PTR_BITS-1:0] wr_idx;
  logic                      primed;
  logic                      play_ok;
  logic                      mute;

  logic                      proc_bank_c;
  logic                      wrap_c;
  logic                      done_c;
  logic                      ovr_hit_c;
  logic                      play_en_c;
  logic [FRAME_W-1:0]        tx_rd_c;
  logic [FRAME_W-1:0]        rd_cand_c;
  logic [SAMPLE_SIZE-1:0]    rd_sel_c;

  assign proc_bank_c = ~bank_sel;
  assign wrap_c      = frame_valid && (wr_idx == CHUNK_PTR_BITS'(CHUNK_LEN - 1));
  // proc_done only counts while a chunk is outstanding
  assign done_c      = proc_done && (state == BUSY);
  // A swap with no coincident proc_done while busy means the processor lost a chunk
  assign ovr_hit_c   = wrap_c && (state == BUSY) && !proc_done;
  assign play_en_c   = play_ok && !mute;

  // Per-channel storage: each channel owns one rx and one tx bank pair
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [SAMPLE_SIZE-1:0] rx_mem [2][CHUNK_LEN];
    logic [SAMPLE_SIZE-1:0] tx_mem [2][CHUNK_LEN];

    // Frame side fills the current rx bank
    always_ff @(posedge clk) begin
      if (frame_valid) begin
        rx_mem[bank_sel][wr_idx] <= frame_in[g*SAMPLE_SIZE +: SAMPLE_SIZE];
      end
    end

    // Processor side writes the opposite tx bank
    always_ff @(posedge clk) begin
      if (proc_wr_en && (proc_wr_ch == CH_BITS'(g))) begin
        tx_mem[proc_bank_c][proc_wr_ptr] <= proc_wr_data;
      end
    end

    assign tx_rd_c[g*SAMPLE_SIZE +: SAMPLE_SIZE]   = tx_mem[bank_sel][wr_idx];
    assign rd_cand_c[g*SAMPLE_SIZE +: SAMPLE_SIZE] = rx_mem[proc_bank_c][proc_rd_ptr];
  end

  // Channel select for processor reads; unmapped channels read as zero
  always_comb begin
    rd_sel_c = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (proc_rd_ch == CH_BITS'(c)) begin
        rd_sel_c = rd_cand_c[c*SAMPLE_SIZE +: SAMPLE_SIZE];
      end
    end
  end

  // Frame pipeline, bank control and processor read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx          <= '0;
      bank_sel        <= 1'b0;
      frame_out       <= '0;
      frame_out_valid <= 1'b0;
      chunk_pulse     <= 1'b0;
      proc_rd_data    <= '0;
      proc_rd_valid   <= 1'b0;
    end else begin
      frame_out_valid <= frame_valid;
      chunk_pulse     <= wrap_c;
      proc_rd_valid   <= proc_rd_en;
      if (proc_rd_en) begin
        proc_rd_data <= rd_sel_c;
      end
      if (frame_valid) begin
        frame_out <= play_en_c ? tx_rd_c : '0;
        if (wrap_c) begin
          wr_idx   <= '0;
          bank_sel <= ~bank_sel;
        end else begin
          wr_idx <= wr_idx + CHUNK_PTR_BITS'(1);
        end
      end
    end
  end

  // Processor handshake FSM plus priming and overrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      proc_busy <= 1'b0;
      primed    <= 1'b0;
      play_ok   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= ovr_hit_c | (overrun & ~overrun_clr);
      if (done_c) begin
        primed <= 1'b1;
      end
      // A play bank is trustworthy once any chunk has been processed,
      // including one finished in the swap cycle itself
      if (wrap_c) begin
        play_ok <= primed | done_c;
      end
      case (state)
        IDLE: begin
          if (wrap_c) begin
            state     <= BUSY;
            proc_busy <= 1'b1;
          end
        end
        BUSY: begin
          // A swap always hands over a new chunk; done alone releases it
          if (wrap_c) begin
            state     <= BUSY;
            proc_busy <= 1'b1;
          end else if (proc_done) begin
            state     <= IDLE;
            proc_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          proc_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef PINGPONG_MUTE_ON_OVERRUN_EN
  // Re-evaluated at every swap: mute the chunk whose tx bank was abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      mute <= 1'b0;
    end else if (wrap_c) begin
      mute <= ovr_hit_c;
    end
  end
`else
  assign mute = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_chunk_buffer.sv
// Testbench for pingpong_chunk_buffer: directed vectors with hand-computed
// expectations, a processor read table and multi-chunk sequences.
module tb_pingpong_chunk_buffer;

  localparam int unsigned SS = 24;
  localparam int unsigned NC = 2;
  localparam int unsigned CB = 2;
  localparam int unsigned CL = 64;
  localparam int unsigned PB = 6;
  localparam int unsigned FW = NC * SS;
`ifdef PINGPONG_MUTE_ON_OVERRUN_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          frame_valid;
  logic [FW-1:0] frame_in;
  logic [FW-1:0] frame_out;
  logic          frame_out_valid;
  logic          chunk_pulse;
  logic          bank_sel;
  logic          proc_rd_en;
  logic [CB-1:0] proc_rd_ch;
  logic [PB-1:0] proc_rd_ptr;
  logic [SS-1:0] proc_rd_data;
  logic          proc_rd_valid;
  logic          proc_wr_en;
  logic [CB-1:0] proc_wr_ch;
  logic [PB-1:0] proc_wr_ptr;
  logic [SS-1:0] proc_wr_data;
  logic          proc_done;
  logic          proc_busy;
  logic          overrun;
  logic          overrun_clr;

  pingpong_chunk_buffer #(
    .SAMPLE_SIZE(SS), .NUM_CHANNELS(NC), .CH_BITS(CB),
    .CHUNK_LEN(CL), .CHUNK_PTR_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_in(frame_in),
    .frame_out(frame_out), .frame_out_valid(frame_out_valid),
    .chunk_pulse(chunk_pulse), .bank_sel(bank_sel),
    .proc_rd_en(proc_rd_en), .proc_rd_ch(proc_rd_ch), .proc_rd_ptr(proc_rd_ptr),
    .proc_rd_data(proc_rd_data), .proc_rd_valid(proc_rd_valid),
    .proc_wr_en(proc_wr_en), .proc_wr_ch(proc_wr_ch), .proc_wr_ptr(proc_wr_ptr),
    .proc_wr_data(proc_wr_data), .proc_done(proc_done), .proc_busy(proc_busy),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CB-1:0] ch;
    logic [PB-1:0] ptr;
    logic          exp_valid;
    logic [SS-1:0] exp_data;
  } rd_vec_t;

  rd_vec_t       rd_tab [8];
  logic [FW-1:0] sent   [0:1023];
  int            fn;
  int            checks;
  int            errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (frame %0d)", name, act, exp, fn);
    end
  endtask

  // Sample of frame n, channel c = {c+1, n}
  function automatic logic [FW-1:0] mk_frame(input int n);
    logic [FW-1:0] f;
    for (int c = 0; c < NC; c++) begin
      f[c*SS +: SS] = {8'(c + 1), 16'(n)};
    end
    return f;
  endfunction

  task automatic clear_inputs();
    frame_valid  = 1'b0;
    frame_in     = '0;
    proc_rd_en   = 1'b0;
    proc_rd_ch   = '0;
    proc_rd_ptr  = '0;
    proc_wr_en   = 1'b0;
    proc_wr_ch   = '0;
    proc_wr_ptr  = '0;
    proc_wr_data = '0;
    proc_done    = 1'b0;
    overrun_clr  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_out"}, 64'(frame_out), 64'd0);
    check({tag, "_frame_out_valid"}, 64'(frame_out_valid), 64'd0);
    check({tag, "_chunk_pulse"}, 64'(chunk_pulse), 64'd0);
    check({tag, "_bank_sel"}, 64'(bank_sel), 64'd0);
    check({tag, "_proc_rd_data"}, 64'(proc_rd_data), 64'd0);
    check({tag, "_proc_rd_valid"}, 64'(proc_rd_valid), 64'd0);
    check({tag, "_proc_busy"}, 64'(proc_busy), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
  endtask

  // Processor copies frame slot i of rx[~bank_sel] into tx[~bank_sel]
  task automatic copy_slot(input int i, input bit chk_rd, input int base);
    logic [SS-1:0] d0;
    logic [SS-1:0] d1;
    logic [FW-1:0] ref_f;
    ref_f       = sent[(base >= CL) ? (base - CL + i) : 0];
    proc_rd_en  = 1'b1;
    proc_rd_ch  = '0;
    proc_rd_ptr = PB'(i);
    tick();
    check("frame_out_valid_gap", 64'(frame_out_valid), 64'd0);
    check("chunk_pulse_gap", 64'(chunk_pulse), 64'd0);
    check("proc_rd_valid", 64'(proc_rd_valid), 64'd1);
    d0 = proc_rd_data;
    if (chk_rd) check("copy_rd_ch0", 64'(d0), 64'(ref_f[0 +: SS]));
    proc_rd_ch   = CB'(1);
    proc_wr_en   = 1'b1;
    proc_wr_ch   = '0;
    proc_wr_ptr  = PB'(i);
    proc_wr_data = d0;
    tick();
    d1 = proc_rd_data;
    if (chk_rd) check("copy_rd_ch1", 64'(d1), 64'(ref_f[SS +: SS]));
    proc_rd_en   = 1'b0;
    proc_wr_ch   = CB'(1);
    proc_wr_data = d1;
    tick();
    check("proc_rd_valid_off", 64'(proc_rd_valid), 64'd0);
    proc_wr_en = 1'b0;
  endtask

  // One chunk of frames. done_mode: 0 none, 1 before the wrap frame,
  // 2 in the wrap cycle. exp_mode: 0 silence, 1 input from 2*CL frames
  // earlier, 2 like 1 unless overrun muting is built in.
  task automatic run_chunk(input bit do_copy, input bit chk_rd, input int done_mode,
                           input int exp_mode, input bit exp_busy, input bit exp_ovr,
                           input bit clr_at_wrap);
    int            base;
    logic [FW-1:0] exp_f;
    base = fn;
    for (int i = 0; i < int'(CL); i++) begin
      if (do_copy) copy_slot(i, chk_rd, base);
      if (i == int'(CL) - 1 && done_mode == 1) begin
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        check("proc_busy_after_done", 64'(proc_busy), 64'd0);
      end
      frame_in    = mk_frame(fn);
      sent[fn]    = frame_in;
      frame_valid = 1'b1;
      proc_done   = (i == int'(CL) - 1) && (done_mode == 2);
      overrun_clr = (i == int'(CL) - 1) && clr_at_wrap;
      tick();
      frame_valid = 1'b0;
      proc_done   = 1'b0;
      overrun_clr = 1'b0;
      if (exp_mode == 0 || (exp_mode == 2 && MUTE_EN)) exp_f = '0;
      else exp_f = sent[fn - 2*int'(CL)];
      check("frame_out_valid", 64'(frame_out_valid), 64'd1);
      check("frame_out", 64'(frame_out), 64'(exp_f));
      check("chunk_pulse", 64'(chunk_pulse), 64'(i == int'(CL) - 1));
      fn++;
    end
    check("proc_busy_at_wrap", 64'(proc_busy), 64'(exp_busy));
    check("overrun_at_wrap", 64'(overrun), 64'(exp_ovr));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fn     = 0;
    // Reads of rx bank 0 after the first chunk (frame n ch c = {c+1, n})
    rd_tab[0] = '{ch: 2'd1, ptr: 6'd5,  exp_valid: 1'b1, exp_data: 24'h020005};
    rd_tab[1] = '{ch: 2'd0, ptr: 6'd5,  exp_valid: 1'b1, exp_data: 24'h010005};
    rd_tab[2] = '{ch: 2'd3, ptr: 6'd5,  exp_valid: 1'b1, exp_data: 24'h000000};
    rd_tab[3] = '{ch: 2'd0, ptr: 6'd0,  exp_valid: 1'b1, exp_data: 24'h010000};
    rd_tab[4] = '{ch: 2'd1, ptr: 6'd63, exp_valid: 1'b1, exp_data: 24'h02003F};
    rd_tab[5] = '{ch: 2'd2, ptr: 6'd63, exp_valid: 1'b1, exp_data: 24'h000000};
    rd_tab[6] = '{ch: 2'd0, ptr: 6'd63, exp_valid: 1'b1, exp_data: 24'h01003F};
    rd_tab[7] = '{ch: 2'd1, ptr: 6'd0,  exp_valid: 1'b1, exp_data: 24'h020000};

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Two chunks with no processor activity: silence, then overrun
    run_chunk(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_chunk(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    fn  = 0;
    check("overrun_after_reset", 64'(overrun), 64'd0);

    // First chunk while idle, then the read table against it
    run_chunk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int v = 0; v < 8; v++) begin
      proc_rd_en  = 1'b1;
      proc_rd_ch  = rd_tab[v].ch;
      proc_rd_ptr = rd_tab[v].ptr;
      tick();
      check("tab_rd_valid", 64'(proc_rd_valid), 64'(rd_tab[v].exp_valid));
      check("tab_rd_data", 64'(proc_rd_data), 64'(rd_tab[v].exp_data));
    end
    proc_rd_en = 1'b0;
    tick();
    check("tab_rd_valid_off", 64'(proc_rd_valid), 64'd0);

    // Copying processor: silence until primed, then 2*CL frame delay
    run_chunk(1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0);
    run_chunk(1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
    // proc_done coincident with the wrap: stays busy, no overrun
    run_chunk(1'b1, 1'b1, 2, 1, 1'b1, 1'b0, 1'b0);
    // Skip proc_done: overrun at the wrap
    run_chunk(1'b1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", 64'(overrun), 64'd0);
    // Skip again with a clear in the wrap cycle: set wins
    run_chunk(1'b1, 1'b1, 0, 2, 1'b1, 1'b1, 1'b1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr2", 64'(overrun), 64'd0);
    // Clean chunks resume processed playback
    run_chunk(1'b1, 1'b1, 1, 2, 1'b1, 1'b0, 1'b0);
    run_chunk(1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0);

    // Reset partway through a chunk while busy
    for (int i = 0; i < 30; i++) begin
      frame_in    = mk_frame(fn);
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      fn++;
    end
    proc_rd_en  = 1'b1;
    proc_rd_ch  = '0;
    proc_rd_ptr = PB'(1);
    tick();
    check("pre_reset_busy", 64'(proc_busy), 64'd1);
    check("pre_reset_rd_valid", 64'(proc_rd_valid), 64'd1);
    rst         = 1'b1;
    frame_valid = 1'b1;
    frame_in    = mk_frame(fn);
    tick();
    rst         = 1'b0;
    frame_valid = 1'b0;
    proc_rd_en  = 1'b0;
    check_all_zero("mid_reset");
    fn = 0;
    run_chunk(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("bank_sel_after_chunk", 64'(bank_sel), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_chunk_buffer.md
Name: pingpong_chunk_buffer

Overview:
- Parametrised multi-channel ping-pong chunk buffer in the single system clock domain, between the I2S frame interface and the block processor.
- Collects CHUNK_LEN input frames of NUM_CHANNELS samples into one rx bank while the processor reads the other rx bank and writes the matching tx bank.
- Plays the previously processed tx bank back out frame by frame.
- Generalises the fixed 64-deep, left-only, two-clock double buffer to N channels, any depth, overrun detection and startup muting.

Parameters:
- SAMPLE_SIZE, 24, bits per sample.
- NUM_CHANNELS, 2, channels per frame.
- CH_BITS, 1, channel index width (≥1, 2^CH_BITS ≥ NUM_CHANNELS).
- CHUNK_LEN, 64, frames per chunk (≥2).
- CHUNK_PTR_BITS, 6, frame index width (2^CHUNK_PTR_BITS ≥ CHUNK_LEN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- frame_valid  in  1  one-cycle strobe: frame_in holds a complete frame.
- frame_in  in  NUM_CHANNELS*SAMPLE_SIZE  channel 0 in LSBs.
- frame_out  out  NUM_CHANNELS*SAMPLE_SIZE  playback frame, same packing.
- frame_out_valid  out  1  one-cycle pulse, frame_out updated.
- chunk_pulse  out  1  one-cycle pulse, new chunk available to processor.
- bank_sel  out  1  current fill/play bank.
- proc_rd_en  in  1  processor read request.
- proc_rd_ch  in  CH_BITS  read channel.
- proc_rd_ptr  in  CHUNK_PTR_BITS  read frame index.
- proc_rd_data  out  SAMPLE_SIZE  read data.
- proc_rd_valid  out  1  read data valid.
- proc_wr_en  in  1  processor write strobe.
- proc_wr_ch  in  CH_BITS  write channel.
- proc_wr_ptr  in  CHUNK_PTR_BITS  write frame index.
- proc_wr_data  in  SAMPLE_SIZE  write data.
- proc_done  in  1  one-cycle pulse, processor finished the chunk.
- proc_busy  out  1  processor chunk outstanding.
- overrun  out  1  sticky overrun flag.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Clocking/reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: wr_idx=0, bank_sel=0, state IDLE, primed=0. All outputs 0: frame_out, frame_out_valid, chunk_pulse, proc_rd_data, proc_rd_valid, proc_busy, overrun.
- Memory contents are not reset. Reset mid-chunk discards the partial chunk and the outstanding processor chunk.
- Banks: rx[2][NUM_CHANNELS][CHUNK_LEN] and tx[2][NUM_CHANNELS][CHUNK_LEN].
  - Fill bank: rx[bank_sel].
  - Play bank: tx[bank_sel].
  - Processor banks: rx[~bank_sel] for reads, tx[~bank_sel] for writes.
  - Frame-side and processor-side accesses never target the same bank; all accesses use pre-edge bank_sel.
- On frame_valid:
  - Write every channel to rx[bank_sel][ch][wr_idx].
  - Read tx[bank_sel][ch][wr_idx].
  - Next cycle: frame_out = read data (all zeros if !primed or muted), frame_out_valid=1 for one cycle.
- Wrap: frame_valid with wr_idx==CHUNK_LEN-1 sets wr_idx=0, toggles bank_sel, and raises chunk_pulse next cycle for one cycle. Otherwise wr_idx increments.
- frame_valid while a previous strobe is still in its 1-cycle pipeline is legal; back-to-back strobes are accepted every cycle.
- Processor read: fixed 1-cycle latency, proc_rd_valid = proc_rd_en delayed 1. Channel ≥ NUM_CHANNELS returns 0 with valid still asserted.
- Processor write: applied on the strobe edge. Channel ≥ NUM_CHANNELS is ignored.
- Processor FSM:
  - IDLE → BUSY on swap.
  - BUSY → IDLE on proc_done.
  - proc_done in IDLE is ignored.
  - Swap in BUSY: overrun=1, state stays BUSY (new chunk).
  - proc_done and swap in the same cycle: done takes effect first → BUSY, no overrun.
  - proc_busy = (state==BUSY).
- primed: set on the first proc_done after reset. Playback is muted until the swap following priming.
- overrun: sticky until overrun_clr. A set and a clear in the same cycle → set wins.
- End-to-end latency: input frame k reappears at frame_out exactly 2*CHUNK_LEN frames later, +1 cycle.

Optional Feature:
- Macro: PINGPONG_MUTE_ON_OVERRUN_EN.
- Defined: a swap that raises overrun also sets a mute flag, and frame_out is forced to zero for that whole play chunk, because the play bank is unfinished. The mute flag is re-evaluated at every swap and cleared on a clean swap.
- Undefined: no mute logic; overrun only sets the flag and the stale or partial tx bank plays as-is.

Test Plan:
- Reset, then 2*CHUNK_LEN frames of ramp data with no proc_done → frame_out all 0; frame_out_valid pulses each frame; chunk_pulse at frames 64 and 128; overrun=1 at frame 128.
- Processor copies rx→tx (64 reads, 64 writes, proc_done) each chunk → frame n output equals input frame n-128 per channel; overrun stays 0.
- Processor read of ch=1, ptr=5 after first chunk → proc_rd_data equals frame 5 ch1 one cycle after proc_rd_en; proc_rd_ch=3 with NUM_CHANNELS=2 → data 0.
- proc_done coincident with wrap cycle → proc_busy stays 1, overrun stays 0; overrun_clr with a simultaneous new overrun → overrun stays 1.
- Assert rst at wr_idx=30 with BUSY → all outputs 0 next cycle; next chunk_pulse only after 64 further frames.
- PINGPONG_MUTE_ON_OVERRUN_EN defined, skip proc_done for one chunk → that play chunk outputs 0; the following clean chunk plays processed data.
